pipe_ctrl: RTL

Pipeline sequencing controller for the RISC-V core: it drives the clock-enable and synchronous-clear inputs of the pipeline registers (PC, fetch→execute, execute→writeback). It resolves branch flushes, load-use stalls, multi-cycle data-memory waits and post-reset boot hold into one coherent set of enables. It sits beside the datapath in the core top level, and all hazard sources feed into it.

---
 rtl/pipe_ctrl_pkg.sv | 14 +
 rtl/pipe_ctrl_perf.sv | 35 +++
 rtl/pipe_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline sequencing controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    FLUSH    = 2'd2,
    MEM_WAIT = 2'd3
  } state_t;

  localparam int DEF_BOOT_CYCLES = 2;
  localparam int DEF_MEM_TIMEOUT = 255;

endpackage

// File: rtl/pipe_ctrl_perf.sv
// Performance counters for pipe_ctrl: stall cycles, flush entries, load-use bubbles.
// Only instantiated when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl_perf (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic        i_bubble,
  output logic [31:0] o_stall_cycles,
  output logic [31:0] o_flush_count,
  output logic [31:0] o_bubble_count
);

  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_count;
  logic [31:0] r_bubble_count;

  // Counters wrap naturally modulo 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
      r_bubble_count <= '0;
    end else begin
      if (i_stall)  r_stall_cycles <= r_stall_cycles + 32'd1;
      if (i_flush)  r_flush_count  <= r_flush_count + 32'd1;
      if (i_bubble) r_bubble_count <= r_bubble_count + 32'd1;
    end
  end

  assign o_stall_cycles = r_stall_cycles;
  assign o_flush_count  = r_flush_count;
  assign o_bubble_count = r_bubble_count;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: merges boot hold, branch flush, load-use and
// data-memory waits into one set of register enables/clears. PIPE_CTRL_PERF_EN adds perf counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int BOOT_CYCLES = DEF_BOOT_CYCLES,
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        br_mispredict,
  input  logic        ld_use_hazard,
  input  logic        mem_req,
  input  logic        mem_ack,
  output logic        pc_ce,
  output logic        fx_ce,
  output logic        fx_clr,
  output logic        xw_ce,
  output logic        xw_clr,
  output logic        mem_busy,
  output logic        boot_done,
  output logic        mem_err
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count,
  output logic [31:0] bubble_count
`endif
);

  localparam int BW = $clog2(BOOT_CYCLES + 1);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYCLES - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);

  state_t        r_state;
  logic [BW-1:0] r_boot_cnt;
  logic [WW-1:0] r_wait_cnt;
  logic          r_boot_done;
  logic          r_mem_err;

  logic w_enter_flush;
  logic w_enter_wait;
  logic w_leave_wait;
  logic w_timeout;

  // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    pc_ce         = 1'b0;
    fx_ce         = 1'b0;
    fx_clr        = 1'b0;
    xw_ce         = 1'b0;
    xw_clr        = 1'b0;
    w_enter_flush = 1'b0;
    w_enter_wait  = 1'b0;
    w_leave_wait  = 1'b0;
    w_timeout     = 1'b0;
    case (r_state)
      BOOT: begin
        fx_clr = 1'b1;
        xw_clr = 1'b1;
      end
      RUN: begin
        if (br_mispredict) begin
          pc_ce         = 1'b1;
          fx_clr        = 1'b1;
          xw_ce         = 1'b1;
          w_enter_flush = 1'b1;
        end else if (mem_req) begin
          // Same-cycle ack streams through; otherwise freeze and start waiting.
          {pc_ce, fx_ce, xw_ce} = {3{mem_ack}};
          w_enter_wait          = !mem_ack;
        end else if (ld_use_hazard) begin
          xw_ce  = 1'b1;
          xw_clr = 1'b1;
        end else begin
          {pc_ce, fx_ce, xw_ce} = 3'b111;
        end
      end
      FLUSH: begin
        pc_ce  = 1'b1;
        fx_clr = 1'b1;
        xw_ce  = 1'b1;
      end
      MEM_WAIT: begin
        if (mem_ack) begin
          {pc_ce, fx_ce, xw_ce} = 3'b111;
          w_leave_wait          = 1'b1;
        end else if (r_wait_cnt == WAIT_LAST) begin
          // Abandon the access: bubble into writeback, resume fetch.
          {pc_ce, fx_ce, xw_ce} = 3'b111;
          xw_clr                = 1'b1;
          w_timeout             = 1'b1;
          w_leave_wait          = 1'b1;
        end
      end
      default: begin
        fx_clr = 1'b1;
        xw_clr = 1'b1;
      end
    endcase
    if (rst) begin
      pc_ce         = 1'b0;
      fx_ce         = 1'b0;
      fx_clr        = 1'b1;
      xw_ce         = 1'b0;
      xw_clr        = 1'b1;
      w_enter_flush = 1'b0;
      w_enter_wait  = 1'b0;
      w_leave_wait  = 1'b0;
      w_timeout     = 1'b0;
    end
  end

  assign mem_busy  = !rst && (r_state == MEM_WAIT);
  assign boot_done = !rst && r_boot_done;
  assign mem_err   = !rst && (r_mem_err || w_timeout);

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= BOOT;
      r_boot_cnt  <= '0;
      r_wait_cnt  <= '0;
      r_boot_done <= 1'b0;
      r_mem_err   <= 1'b0;
    end else begin
      case (r_state)
        BOOT: begin
          r_boot_cnt <= r_boot_cnt + 1'b1;
          if (r_boot_cnt == BOOT_LAST) begin
            r_state     <= RUN;
            r_boot_done <= 1'b1;
          end
        end
        RUN: begin
          if (w_enter_flush) begin
            r_state <= FLUSH;
          end else if (w_enter_wait) begin
            r_state    <= MEM_WAIT;
            r_wait_cnt <= '0;
          end
        end
        FLUSH: r_state <= RUN;
        MEM_WAIT: begin
          if (~&r_wait_cnt) r_wait_cnt <= r_wait_cnt + 1'b1;
          if (w_leave_wait) r_state <= RUN;
          if (w_timeout)    r_mem_err <= 1'b1;
        end
        default: r_state <= BOOT;
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic w_stall;
  logic w_bubble;

  assign w_stall  = !rst && (r_state != BOOT) && !pc_ce;
  assign w_bubble = !rst && (r_state == RUN) && xw_clr;

  pipe_ctrl_perf u_perf (
    .clk            (clk),
    .rst            (rst),
    .i_stall        (w_stall),
    .i_flush        (w_enter_flush),
    .i_bubble       (w_bubble),
    .o_stall_cycles (stall_cycles),
    .o_flush_count  (flush_count),
    .o_bubble_count (bubble_count)
  );
`endif

endmodule
